// File: rtl/cipher_pkg.sv
// Shared constants and types for the cipher input sequencer and the
// processor/memory wrapper it drives.
package cipher_pkg;

  localparam logic [1:0] CPU_IDLE  = 2'b00;
  localparam logic [1:0] CPU_WRITE = 2'b01;
  localparam logic [1:0] CPU_EXEC  = 2'b10;

  localparam logic [1:0] PROG_EN = 2'b01;
  localparam logic [1:0] PROG_BF = 2'b10;

  localparam int RAM_CHAR_BASE = 1500;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_WRITE,
    ST_TERM,
    ST_EXEC,
    ST_DONE
  } seq_state_t;

endpackage

// File: rtl/char_fifo.sv
// Circular character FIFO. The depth need not be a power of two; pointers
// wrap explicitly at DEPTH-1.
module char_fifo #(
  parameter int DEPTH = 108,
  localparam int CW   = $clog2(DEPTH + 1),
  localparam int PW   = $clog2(DEPTH)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          push,
  input  logic [7:0]    din,
  input  logic          pop,
  output logic [7:0]    head,
  output logic [CW-1:0] count,
  output logic          empty,
  output logic          full
);

  localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  // NOTE: every variable gets a default first so no path leaves it unassigned
  // and no latch is inferred.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
    end
    count_d = count_q + {{(CW-1){1'b0}}, push} - {{(CW-1){1'b0}}, pop};
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples its pre-edge inputs regardless of statement order.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is deliberately not reset; the pointers and count alone
  // define which entries are valid, so a flush is just a pointer reset.
  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr_q] <= din;
    end
  end

  assign head  = mem[rd_ptr_q];
  assign count = count_q;
  assign empty = (count_q == '0);
  assign full  = (count_q == CNT_FULL);

endmodule

// File: rtl/cipher_input_sequencer.sv
// Buffers input characters, then drives the wrapper through a
// shift-load / RAM-write / execute run and pulses done.
module cipher_input_sequencer
  import cipher_pkg::*;
#(
  parameter int BUF_DEPTH   = 108,
  parameter int EXEC_CYCLES = 5000,
  parameter int CNT_W       = 13
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       char_valid,
  input  logic [7:0] char_in,
  output logic       char_ready,
  input  logic       start,
  input  logic [4:0] shift_in,
  input  logic [1:0] prog_in,
  output logic [7:0] char_buffer_data,
  output logic [1:0] cpu_en,
  output logic [4:0] shift_amt_data,
  output logic [1:0] program_sel,
  output logic       busy,
  output logic       done
);

  localparam int            CW        = $clog2(BUF_DEPTH + 1);
  localparam logic [CW-1:0] LAST_SLOT = CW'(BUF_DEPTH - 1);
  localparam logic [CNT_W-1:0] EXEC_LAST = CNT_W'(EXEC_CYCLES - 1);

  seq_state_t       state_q, state_d;
  logic [CNT_W-1:0] exec_cnt_q, exec_cnt_d;

  logic          fifo_push, fifo_pop, fifo_empty, fifo_full;
  logic [7:0]    fifo_head;
  logic [CW-1:0] fifo_count, count_nxt;
  logic          start_acc;

  logic       char_ready_q, char_ready_d;
  logic [7:0] char_data_q, char_data_d;
  logic [1:0] cpu_en_q, cpu_en_d;
  logic [4:0] shift_amt_q, shift_amt_d;
  logic [1:0] program_sel_q, program_sel_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;

  char_fifo #(.DEPTH(BUF_DEPTH)) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (fifo_push),
    .din   (char_in),
    .pop   (fifo_pop),
    .head  (fifo_head),
    .count (fifo_count),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  // char_ready_q is only ever high in IDLE, so this also confines pushes there.
  assign fifo_push = char_valid && char_ready_q && !fifo_full;
  assign start_acc = (state_q == ST_IDLE) && start;

  always_comb begin
    state_d    = state_q;
    exec_cnt_d = '0;
    unique case (state_q)
      ST_IDLE:  if (start) state_d = ST_SHIFT;
      ST_SHIFT: state_d = fifo_empty ? ST_TERM : ST_WRITE;
      ST_WRITE: if (fifo_empty) state_d = ST_TERM;
      ST_TERM:  state_d = ST_EXEC;
      ST_EXEC: begin
        if (exec_cnt_q == EXEC_LAST) state_d = ST_DONE;
        else                         exec_cnt_d = exec_cnt_q + 1'b1;
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Popping on entry to each WRITE cycle lets the head land in the output
  // register on the same edge, keeping every output registered.
  assign fifo_pop  = (state_d == ST_WRITE);
  assign count_nxt = fifo_count + {{(CW-1){1'b0}}, fifo_push}
                                - {{(CW-1){1'b0}}, fifo_pop};

  always_comb begin
    char_ready_d  = (state_d == ST_IDLE) && (count_nxt < LAST_SLOT);
    char_data_d   = (state_d == ST_WRITE) ? fifo_head : 8'h00;
    shift_amt_d   = (state_d == ST_SHIFT) ? shift_in : 5'd0;
    busy_d        = (state_d != ST_IDLE);
    done_d        = (state_d == ST_DONE);
    program_sel_d = program_sel_q;
    if (start_acc)                program_sel_d = prog_in;
    else if (state_d == ST_IDLE)  program_sel_d = 2'b00;
    unique case (state_d)
      ST_WRITE, ST_TERM: cpu_en_d = CPU_WRITE;
      ST_EXEC:           cpu_en_d = CPU_EXEC;
      default:           cpu_en_d = CPU_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      exec_cnt_q    <= '0;
      char_ready_q  <= 1'b0;
      char_data_q   <= '0;
      cpu_en_q      <= CPU_IDLE;
      shift_amt_q   <= '0;
      program_sel_q <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      exec_cnt_q    <= exec_cnt_d;
      char_ready_q  <= char_ready_d;
      char_data_q   <= char_data_d;
      cpu_en_q      <= cpu_en_d;
      shift_amt_q   <= shift_amt_d;
      program_sel_q <= program_sel_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  assign char_ready       = char_ready_q;
  assign char_buffer_data = char_data_q;
  assign cpu_en           = cpu_en_q;
  assign shift_amt_data   = shift_amt_q;
  assign program_sel      = program_sel_q;
  assign busy             = busy_q;
  assign done             = done_q;

endmodule

// File: tb/tb_cipher_input_sequencer.sv
// Directed bench for cipher_input_sequencer: buffered runs, full buffer,
// empty buffer, ignored start while busy, same-cycle push+start, async reset.
module tb_cipher_input_sequencer;

  localparam int BUF_DEPTH   = 108;
  localparam int EXEC_CYCLES = 5000;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       char_valid = 1'b0;
  logic [7:0] char_in = 8'h00;
  logic       char_ready;
  logic       start = 1'b0;
  logic [4:0] shift_in = 5'd0;
  logic [1:0] prog_in = 2'b00;
  logic [7:0] char_buffer_data;
  logic [1:0] cpu_en;
  logic [4:0] shift_amt_data;
  logic [1:0] program_sel;
  logic       busy;
  logic       done;

  int n_vec = 0;
  int n_err = 0;
  logic [7:0] model_q [$];

  cipher_input_sequencer #(
    .BUF_DEPTH   (BUF_DEPTH),
    .EXEC_CYCLES (EXEC_CYCLES),
    .CNT_W       (13)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .char_valid       (char_valid),
    .char_in          (char_in),
    .char_ready       (char_ready),
    .start            (start),
    .shift_in         (shift_in),
    .prog_in          (prog_in),
    .char_buffer_data (char_buffer_data),
    .cpu_en           (cpu_en),
    .shift_amt_data   (shift_amt_data),
    .program_sel      (program_sel),
    .busy             (busy),
    .done             (done)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_cpu_en"}, {30'd0, cpu_en}, 32'd0);
    check({tag, "_data"},   {24'd0, char_buffer_data}, 32'd0);
    check({tag, "_shift"},  {27'd0, shift_amt_data}, 32'd0);
    check({tag, "_prog"},   {30'd0, program_sel}, 32'd0);
    check({tag, "_busy"},   {31'd0, busy}, 32'd0);
    check({tag, "_done"},   {31'd0, done}, 32'd0);
  endtask

  task automatic push(input logic [7:0] c);
    bit exp_rdy;
    exp_rdy = (model_q.size() < BUF_DEPTH - 1);
    check("push_ready", {31'd0, char_ready}, {31'd0, exp_rdy});
    char_valid = 1'b1;
    char_in    = c;
    tick();
    char_valid = 1'b0;
    if (exp_rdy) model_q.push_back(c);
  endtask

  // One complete run; expected bytes come from model_q plus the NUL.
  task automatic run(input logic [4:0] sh, input logic [1:0] pr, input bit hold,
                     input bit hammer, input bit with_char, input logic [7:0] c);
    int k;
    int n;
    logic [7:0] exp_b;
    start    = 1'b1;
    shift_in = sh;
    prog_in  = pr;
    if (with_char) begin
      check("same_cycle_ready", {31'd0, char_ready}, 32'd1);
      char_valid = 1'b1;
      char_in    = c;
      model_q.push_back(c);
    end
    tick();
    if (!hold) start = 1'b0;
    char_valid = hammer;
    check("shift_amt", {27'd0, shift_amt_data}, {27'd0, sh});
    check("shift_prog", {30'd0, program_sel}, {30'd0, pr});
    check("shift_cpu_en", {30'd0, cpu_en}, 32'd0);
    check("shift_busy", {31'd0, busy}, 32'd1);
    check("shift_ready", {31'd0, char_ready}, 32'd0);
    tick();
    k = 0;
    while (cpu_en == 2'b01 && k < 200) begin
      exp_b = (k < model_q.size()) ? model_q[k] : 8'h00;
      check($sformatf("write_byte%0d", k), {24'd0, char_buffer_data}, {24'd0, exp_b});
      k++;
      tick();
    end
    check("write_cycles", k, model_q.size() + 1);
    model_q.delete();
    n = 0;
    while (cpu_en == 2'b10 && n < EXEC_CYCLES + 100) begin
      if (n == 10) begin
        check("exec_ready", {31'd0, char_ready}, 32'd0);
        check("exec_data", {24'd0, char_buffer_data}, 32'd0);
      end
      n++;
      tick();
    end
    check("exec_cycles", n, EXEC_CYCLES);
    check("done_pulse", {31'd0, done}, 32'd1);
    check("done_cpu_en", {30'd0, cpu_en}, 32'd0);
    check("done_prog", {30'd0, program_sel}, {30'd0, pr});
    tick();
    start      = 1'b0;
    char_valid = 1'b0;
    check("idle_busy", {31'd0, busy}, 32'd0);
    check("idle_done", {31'd0, done}, 32'd0);
    check("idle_prog", {30'd0, program_sel}, 32'd0);
    check("idle_ready", {31'd0, char_ready}, 32'd1);
    tick();
    check("no_restart", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int n;
    #2;
    check_quiet("reset");
    check("reset_ready", {31'd0, char_ready}, 32'd0);
    #20 reset = 1'b1;
    tick();
    check("ready_after_reset", {31'd0, char_ready}, 32'd1);

    // "ABC", shift 3, EN program
    push(8'h41); push(8'h42); push(8'h43);
    run(5'd3, 2'b01, 1'b0, 1'b0, 1'b0, 8'h00);

    // Fill to 107; the 108th is refused
    for (int i = 0; i < BUF_DEPTH - 1; i++) push(8'h20 + 8'(i % 90));
    check("full_ready", {31'd0, char_ready}, 32'd0);
    push(8'h7e);
    run(5'd17, 2'b10, 1'b0, 1'b0, 1'b0, 8'h00);

    // Empty buffer, shift 0, start held and char_valid hammered while busy
    run(5'd0, 2'b10, 1'b1, 1'b1, 1'b0, 8'h00);

    // Push "Z" on the start cycle; also shows the hammered chars were refused
    run(5'd5, 2'b01, 1'b0, 1'b0, 1'b1, 8'h5a);

    // Async reset mid-EXEC
    push(8'h51);
    start = 1'b1; shift_in = 5'd9; prog_in = 2'b01;
    tick();
    start = 1'b0;
    n = 0;
    while (cpu_en != 2'b10 && n < 50) begin n++; tick(); end
    check("reach_exec", {30'd0, cpu_en}, 32'd2);
    repeat (100) tick();
    #1 reset = 1'b0;
    #1;
    check_quiet("async_reset");
    check("async_reset_ready", {31'd0, char_ready}, 32'd0);
    model_q.delete();
    tick(); tick();
    #1 reset = 1'b1;
    tick();
    check("ready_after_rereset", {31'd0, char_ready}, 32'd1);
    push(8'h41); push(8'h42); push(8'h43);
    run(5'd3, 2'b01, 1'b0, 1'b0, 1'b0, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
